// File: rtl/pulse_accumulator.sv
// pulse_accumulator: counts p_in events (level or rising-edge mode), wraps at
// PERIOD with a one-cycle tc strobe, and raises a sticky irq plus a missed
// flag for terminal counts that arrive while irq is still pending.
// Optional capture register enabled by `define PULSE_ACCUMULATOR_CAPTURE_EN.
module pulse_accumulator #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned PERIOD    = 16'hFFFF,
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             p_in,
  input  logic             enable,
  input  logic             load,
  input  logic             irq_ack,
`ifdef PULSE_ACCUMULATOR_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] captured,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             irq,
  output logic             missed
);

  localparam logic [WIDTH-1:0] PERIOD_W = WIDTH'(PERIOD);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } irq_state_e;

  logic             p_prev_q, p_prev_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             missed_q, missed_d;
  irq_state_e       state_q, state_d;
  logic             ev;
  logic             wrap;

  // Event detect; edge history follows p_in every cycle regardless of enable/load.
  always_comb begin
    p_prev_d = p_in;
    if (EDGE_MODE != 0) begin
      ev = p_in & ~p_prev_q & enable;
    end else begin
      ev = p_in & enable;
    end
  end

  // Counter next state: load has priority over events; wrap at PERIOD.
  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (load) begin
      count_d = '0;
    end else if (ev) begin
      if (count_q == PERIOD_W) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
    tc_d = wrap;
  end

  // IRQ FSM: a wrap coinciding with an ack re-arms the request and clears missed.
  always_comb begin
    state_d  = state_q;
    missed_d = missed_q;
    case (state_q)
      IDLE: begin
        if (wrap) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (wrap && !irq_ack) begin
          missed_d = 1'b1;
        end else if (irq_ack && !wrap) begin
          state_d  = IDLE;
          missed_d = 1'b0;
        end else if (irq_ack && wrap) begin
          missed_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        missed_d = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_prev_q <= 1'b0;
      count_q  <= '0;
      tc_q     <= 1'b0;
      missed_q <= 1'b0;
      state_q  <= IDLE;
    end else begin
      p_prev_q <= p_prev_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
      missed_q <= missed_d;
      state_q  <= state_d;
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign irq    = (state_q == PEND);
  assign missed = missed_q;

`ifdef PULSE_ACCUMULATOR_CAPTURE_EN
  logic [WIDTH-1:0] captured_q, captured_d;

  // Capture samples the count as it stood before this edge's update.
  always_comb begin
    captured_d = captured_q;
    if (capture) begin
      captured_d = count_q;
    end
  end

  // Capture register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      captured_q <= '0;
    end else begin
      captured_q <= captured_d;
    end
  end

  assign captured = captured_q;
`endif

endmodule

// File: tb/tb_pulse_accumulator.sv
// Bench for pulse_accumulator: four configurations driven by shared inputs,
// checked every cycle against an event-count model plus literal expectations.
module tb_pulse_accumulator;

  localparam int NDUT = 4;

  logic clock = 1'b0;
  logic reset_n, p_in, enable, load, irq_ack, capture;
  logic [7:0] cnt_o [NDUT];
  logic       tc_o  [NDUT];
  logic       irq_o [NDUT];
  logic       mis_o [NDUT];
  logic [7:0] cap_o [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned PER = (g == 2) ? 9 : (g == 3) ? 1 : 3;
    localparam int unsigned EM  = (g == 1) ? 1 : 0;
    pulse_accumulator #(.WIDTH(8), .PERIOD(PER), .EDGE_MODE(EM)) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .p_in    (p_in),
      .enable  (enable),
      .load    (load),
      .irq_ack (irq_ack),
`ifdef PULSE_ACCUMULATOR_CAPTURE_EN
      .capture (capture),
      .captured(cap_o[g]),
`endif
      .count   (cnt_o[g]),
      .tc      (tc_o[g]),
      .irq     (irq_o[g]),
      .missed  (mis_o[g])
    );
`ifndef PULSE_ACCUMULATOR_CAPTURE_EN
    assign cap_o[g] = 8'd0;
`endif
  end

  function automatic int unsigned per_of(int i);
    return (i == 2) ? 9 : (i == 3) ? 1 : 3;
  endfunction
  function automatic bit em_of(int i);
    return (i == 1);
  endfunction

  // Model: events since last clear; count is that total modulo PERIOD+1.
  int unsigned m_ev   [NDUT];
  bit          m_tc   [NDUT];
  bit          m_irq  [NDUT];
  bit          m_mis  [NDUT];
  bit          m_prev [NDUT];
  int unsigned m_cap  [NDUT];

  function automatic int unsigned m_count(int i);
    return m_ev[i] % (per_of(i) + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_ev[i] = 0; m_tc[i] = 0; m_irq[i] = 0; m_mis[i] = 0; m_prev[i] = 0; m_cap[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NDUT; i++) begin
      bit ev, wrap;
      ev   = p_in && enable && (!em_of(i) || !m_prev[i]);
      wrap = !load && ev && (m_count(i) == per_of(i));
      if (capture) m_cap[i] = m_count(i);
      if (load) m_ev[i] = 0;
      else if (ev) m_ev[i] = m_ev[i] + 1;
      m_tc[i] = wrap;
      if (wrap) begin
        if (m_irq[i] && !irq_ack) m_mis[i] = 1;
        else m_mis[i] = 0;
        m_irq[i] = 1;
      end else if (irq_ack) begin
        m_irq[i] = 0;
        m_mis[i] = 0;
      end
      m_prev[i] = p_in;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("count[%0d]", i), 32'(cnt_o[i]), m_count(i));
      check($sformatf("tc[%0d]", i), 32'(tc_o[i]), 32'(m_tc[i]));
      check($sformatf("irq[%0d]", i), 32'(irq_o[i]), 32'(m_irq[i]));
      check($sformatf("missed[%0d]", i), 32'(mis_o[i]), 32'(m_mis[i]));
`ifdef PULSE_ACCUMULATOR_CAPTURE_EN
      check($sformatf("captured[%0d]", i), 32'(cap_o[i]), m_cap[i]);
`endif
    end
  endtask

  // Inputs are set at the falling edge; the model steps on the rising edge.
  task automatic tick();
    @(posedge clock);
    if (reset_n) model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic pulse();
    p_in = 1'b1; tick();
    p_in = 1'b0; tick();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst_count[%0d]", i), 32'(cnt_o[i]), 32'd0);
      check($sformatf("rst_tc[%0d]", i), 32'(tc_o[i]), 32'd0);
      check($sformatf("rst_irq[%0d]", i), 32'(irq_o[i]), 32'd0);
      check($sformatf("rst_missed[%0d]", i), 32'(mis_o[i]), 32'd0);
    end
    @(posedge clock);
    @(negedge clock);
    compare_all();
    reset_n = 1'b1;
  endtask

  initial begin
    int exp_seq [10];
    exp_seq = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    reset_n = 1'b0; p_in = 1'b0; enable = 1'b1; load = 1'b0; irq_ack = 1'b0; capture = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    check("reset_count0", 32'(cnt_o[0]), 32'd0);
    reset_n = 1'b1;

    // Ten isolated pulses, PERIOD=3 level mode.
    for (int k = 0; k < 10; k++) begin
      p_in = 1'b1; tick();
      check("seq_count", 32'(cnt_o[0]), 32'(exp_seq[k]));
      check("seq_tc", 32'(tc_o[0]), 32'(k == 3 || k == 7));
      if (k == 3) check("seq_irq", 32'(irq_o[0]), 32'd1);
      p_in = 1'b0; tick();
      check("seq_tc_idle", 32'(tc_o[0]), 32'd0);
    end

    // Clear and acknowledge.
    load = 1'b1; irq_ack = 1'b1; tick();
    load = 1'b0; irq_ack = 1'b0;

    // Held high 5, low 1, high 3: edge mode counts 2, level mode counts 8.
    p_in = 1'b1; repeat (5) tick();
    p_in = 1'b0; tick();
    p_in = 1'b1; repeat (3) tick();
    p_in = 1'b0; tick();
    check("hold_level_p3", 32'(cnt_o[0]), 32'd0);
    check("hold_edge_p3", 32'(cnt_o[1]), 32'd2);
    check("hold_level_p9", 32'(cnt_o[2]), 32'd8);
    check("hold_irq_p1", 32'(irq_o[3]), 32'd1);
    check("hold_missed_p1", 32'(mis_o[3]), 32'd1);

    // Acknowledge clears irq and missed.
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("ack_irq_p1", 32'(irq_o[3]), 32'd0);
    check("ack_missed_p1", 32'(mis_o[3]), 32'd0);

    // Ack coinciding with a wrap while pending.
    pulse(); pulse();
    check("rearm_irq_p1", 32'(irq_o[3]), 32'd1);
    pulse();
    p_in = 1'b1; irq_ack = 1'b1; tick();
    p_in = 1'b0; irq_ack = 1'b0;
    check("ackwrap_irq_p1", 32'(irq_o[3]), 32'd1);
    check("ackwrap_missed_p1", 32'(mis_o[3]), 32'd0);
    check("ackwrap_tc_p1", 32'(tc_o[3]), 32'd1);
    tick();

    // Load beats a simultaneous event.
    load = 1'b1; tick(); load = 1'b0;
    pulse(); pulse();
    check("pre_load_count", 32'(cnt_o[0]), 32'd2);
    p_in = 1'b1; load = 1'b1; tick();
    p_in = 1'b0; load = 1'b0;
    check("load_count", 32'(cnt_o[0]), 32'd0);
    check("load_tc", 32'(tc_o[0]), 32'd0);

    // Enable low ignores events.
    pulse(); pulse();
    enable = 1'b0;
    repeat (4) pulse();
    enable = 1'b1;
    check("disabled_count", 32'(cnt_o[0]), 32'd2);

    // Capture concurrent with a pulse at count 5.
    load = 1'b1; tick(); load = 1'b0;
    repeat (5) pulse();
    check("pre_cap_count_p9", 32'(cnt_o[2]), 32'd5);
    p_in = 1'b1; capture = 1'b1; tick();
    p_in = 1'b0; capture = 1'b0;
    check("cap_count_p9", 32'(cnt_o[2]), 32'd6);
`ifdef PULSE_ACCUMULATOR_CAPTURE_EN
    check("captured_p9", 32'(cap_o[2]), 32'd5);
`endif
    tick();

    // Reset mid-count with p_in held high: release counts as one edge.
    p_in = 1'b1;
    do_reset();
    tick();
    check("post_reset_edge", 32'(cnt_o[1]), 32'd1);
    tick();
    check("post_reset_hold_edge", 32'(cnt_o[1]), 32'd1);
    check("post_reset_hold_level", 32'(cnt_o[0]), 32'd2);
    p_in = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      p_in    = ($urandom_range(0, 2) != 0);
      enable  = ($urandom_range(0, 9) != 0);
      load    = ($urandom_range(0, 24) == 0);
      irq_ack = ($urandom_range(0, 7) == 0);
      capture = ($urandom_range(0, 5) == 0);
      tick();
      if (c == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
